// File: rtl/spart_pkg.sv
// Shared definitions for the SPART echo driver.
// Provides the SPART register addresses, the FSM state type, and helpers
// that turn a baud select code into a baud rate and into a 16-bit divisor.
package spart_pkg;

    // SPART register map as seen on ioaddr
    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    // Bus master states; every non-IDLE state is exactly one bus access
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG_LO  = 3'd1,
        ST_CFG_HI  = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4
    } state_t;

    // Baud rate selected by the DIP switches
    function automatic int unsigned baud_of(input logic [1:0] sel);
        int unsigned baud;
        case (sel)
            2'b00:   baud = 4800;
            2'b01:   baud = 9600;
            2'b10:   baud = 19200;
            default: baud = 38400;
        endcase
        return baud;
    endfunction

    // SPART divisor for 16x oversampling, truncated toward zero
    function automatic logic [15:0] div_of(input int unsigned clk_hz, input logic [1:0] sel);
        int unsigned div_full;
        div_full = clk_hz / (16 * baud_of(sel));
        return div_full[15:0];
    endfunction

endpackage

// File: rtl/spart_echo_driver_if.sv
// SPART bus between the echo driver (master) and the SPART (slave).
// Signals: iocs chip select, iorw (1=read, 0=write), ioaddr register
// address, rda receive data available, tbr transmit buffer ready, and the
// shared tri-state databus.
interface spart_echo_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    wire  [7:0] databus;

    modport master (
        output iocs, iorw, ioaddr,
        input  rda, tbr,
        inout  databus
    );

    modport slave (
        input  iocs, iorw, ioaddr,
        output rda, tbr,
        inout  databus
    );
endinterface

// File: rtl/spart_echo_driver_echo_fifo.sv
// Circular echo buffer holding received bytes until they can be sent back.
// Ports: clk, rst (async active-low), push/pop strobes, din write data,
// dout head entry (combinational), full/empty flags, count occupancy.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module echo_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage has no reset; stale entries are unreachable once count is 0
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spart_echo_driver.sv
// SPART echo driver: bus master that programs the SPART baud divisor from
// the DIP switches and echoes every received byte back through a FIFO.
// Ports: clk, rst (async active-low), br_cfg baud select, bus (SPART bus
// master modport), fifo_count echo buffer occupancy, overflow sticky flag
// set when a received byte had to be dropped.
module spart_echo_driver
    import spart_pkg::*;
#(
    parameter  int CLK_FREQ_HZ = 25000000,
    parameter  int FIFO_DEPTH  = 8,
    parameter  int TBR_HOLDOFF = 2,
    localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           br_cfg,
    spart_echo_driver_if.master  bus,
    output logic [CW-1:0]        fifo_count,
    output logic                 overflow
);

    localparam logic [15:0] DIV_4800  = div_of(CLK_FREQ_HZ, 2'b00);
    localparam logic [15:0] DIV_9600  = div_of(CLK_FREQ_HZ, 2'b01);
    localparam logic [15:0] DIV_19200 = div_of(CLK_FREQ_HZ, 2'b10);
    localparam logic [15:0] DIV_38400 = div_of(CLK_FREQ_HZ, 2'b11);

    state_t      state;
    logic [1:0]  br_cfg_q;
    logic [3:0]  holdoff;
    logic [15:0] div_sel;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic        drive_en;
    logic [7:0]  drive_val;
    logic        iocs_c;
    logic        iorw_c;
    logic [1:0]  ioaddr_c;

    always_comb begin
        case (br_cfg)
            2'b00:   div_sel = DIV_4800;
            2'b01:   div_sel = DIV_9600;
            2'b10:   div_sel = DIV_19200;
            default: div_sel = DIV_38400;
        endcase
    end

    // A push while full is ignored by the FIFO; the drop is flagged below
    echo_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (state == ST_RD_DATA),
        .pop   (state == ST_WR_DATA),
        .din   (bus.databus),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // br_cfg_q is always recaptured in CFG_HI before it is ever compared,
    // so a constant reset value behaves the same as sampling br_cfg here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_CFG_LO;
            br_cfg_q <= 2'b00;
            holdoff  <= 4'd0;
            overflow <= 1'b0;
        end else begin
            if (state == ST_WR_DATA) begin
                holdoff <= 4'(TBR_HOLDOFF);
            end else if (holdoff != 4'd0) begin
                holdoff <= holdoff - 4'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (br_cfg != br_cfg_q) begin
                        state <= ST_CFG_LO;
                    end else if (bus.rda) begin
                        state <= ST_RD_DATA;
                    end else if (bus.tbr && holdoff == 4'd0 && !fifo_empty) begin
                        state <= ST_WR_DATA;
                    end
                end
                ST_CFG_LO: begin
                    state <= ST_CFG_HI;
                end
                ST_CFG_HI: begin
                    br_cfg_q <= br_cfg;
                    state    <= ST_IDLE;
                end
                ST_RD_DATA: begin
                    if (fifo_full) begin
                        overflow <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus outputs decode the state but are forced idle while rst is low so
    // an access in flight is abandoned the moment reset asserts
    always_comb begin
        iocs_c    = 1'b0;
        iorw_c    = 1'b1;
        ioaddr_c  = ADDR_DATA;
        drive_en  = 1'b0;
        drive_val = 8'h00;
        if (rst) begin
            case (state)
                ST_CFG_LO: begin
                    iocs_c    = 1'b1;
                    iorw_c    = 1'b0;
                    ioaddr_c  = ADDR_DIV_LO;
                    drive_en  = 1'b1;
                    drive_val = div_sel[7:0];
                end
                ST_CFG_HI: begin
                    iocs_c    = 1'b1;
                    iorw_c    = 1'b0;
                    ioaddr_c  = ADDR_DIV_HI;
                    drive_en  = 1'b1;
                    drive_val = div_sel[15:8];
                end
                ST_RD_DATA: begin
                    iocs_c = 1'b1;
                end
                ST_WR_DATA: begin
                    iocs_c    = 1'b1;
                    iorw_c    = 1'b0;
                    drive_en  = 1'b1;
                    drive_val = fifo_head;
                end
                default: begin
                    iocs_c = 1'b0;
                end
            endcase
        end
    end

    assign bus.iocs    = iocs_c;
    assign bus.iorw    = iorw_c;
    assign bus.ioaddr  = ioaddr_c;
    assign bus.databus = drive_en ? drive_val : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_spart_echo_driver.sv
// Testbench for spart_echo_driver: plays the SPART side of the bus,
// keeps a queue-based model of the echo buffer and checks every bus access.
module tb_spart_echo_driver;
    import spart_pkg::*;

    localparam int CLK_HZ = 25000000;
    localparam int DEPTH  = 8;
    localparam int HOLD   = 2;
    localparam int CW     = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    br_cfg = 2'b00;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          probe = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          tb_drv_en;
    logic [7:0]    tb_drv_val;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;
    int         cyc = 0;
    int         last_tx = -1000;
    int         tx_total = 0;
    int         cfg_writes = 0;
    bit         prev_acc = 1'b0;
    logic [1:0] prev_addr = 2'b00;
    logic [7:0] last_lo = 8'h00;
    logic [7:0] last_hi = 8'h00;

    spart_echo_driver_if bus_if();

    spart_echo_driver #(
        .CLK_FREQ_HZ (CLK_HZ),
        .FIFO_DEPTH  (DEPTH),
        .TBR_HOLDOFF (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .bus        (bus_if),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // SPART side drives the bus on data reads; probe drives a marker to
    // show that nothing else is driving the bus
    always_comb begin
        tb_drv_en  = probe || (bus_if.iocs && bus_if.iorw && bus_if.ioaddr == ADDR_DATA);
        tb_drv_val = probe ? 8'h5A : rx_byte;
    end
    assign bus_if.databus = tb_drv_en ? tb_drv_val : 8'bzzzz_zzzz;

    function automatic logic [15:0] tbDiv(input logic [1:0] sel);
        int baud;
        baud = 4800 * (1 << sel);
        return 16'(CLK_HZ / (16 * baud));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Present one received byte; rda stays high until the driver reads it
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n = 0;
        rx_byte = b;
        bus_if.rda = 1'b1;
        do begin
            tick();
            n++;
        end while (!(bus_if.iocs && bus_if.iorw && bus_if.ioaddr == ADDR_DATA) && n < 50);
        checkOutput("rd_timeout", 32'(n < 50), 32'd1);
        bus_if.rda = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus_if.tbr = 1'b1;
        while ((model_q.size() != 0 || fifo_count != '0) && n < 400) begin
            tick();
            n++;
        end
        checkOutput("drain_timeout", 32'(n < 400), 32'd1);
        repeat (HOLD + 2) tick();
    endtask

    // Bus monitor: scoreboard of received/transmitted bytes and divisors
    always @(negedge clk) begin : monitor
        logic [15:0] div_exp;
        logic [7:0]  exp_tx;
        cyc++;
        if (!rst) begin
            prev_acc = 1'b0;
            last_tx  = -1000;
        end else begin
            checkOutput("fifo_count", 32'(fifo_count), model_q.size());
            checkOutput("overflow", 32'(overflow), 32'(model_ovf));
            if (bus_if.iocs) begin
                checkOutput("no_status_access", 32'(bus_if.ioaddr != ADDR_STATUS), 32'd1);
                if (prev_acc) begin
                    checkOutput("access_gap", 32'(prev_addr == ADDR_DIV_LO && bus_if.ioaddr == ADDR_DIV_HI), 32'd1);
                end
                div_exp = tbDiv(br_cfg);
                if (bus_if.iorw) begin
                    checkOutput("read_addr", 32'(bus_if.ioaddr), 32'(ADDR_DATA));
                    if (model_q.size() < DEPTH) model_q.push_back(rx_byte);
                    else model_ovf = 1'b1;
                end else begin
                    case (bus_if.ioaddr)
                        ADDR_DIV_LO: begin
                            checkOutput("div_lo", 32'(bus_if.databus), 32'(div_exp[7:0]));
                            last_lo = bus_if.databus;
                            cfg_writes++;
                        end
                        ADDR_DIV_HI: begin
                            checkOutput("div_hi", 32'(bus_if.databus), 32'(div_exp[15:8]));
                            last_hi = bus_if.databus;
                        end
                        ADDR_DATA: begin
                            checkOutput("tx_nonempty", 32'(model_q.size() != 0), 32'd1);
                            if (model_q.size() != 0) begin
                                exp_tx = model_q.pop_front();
                                checkOutput("tx_data", 32'(bus_if.databus), 32'(exp_tx));
                            end
                            checkOutput("tbr_holdoff", 32'(cyc - last_tx > HOLD), 32'd1);
                            last_tx = cyc;
                            tx_total++;
                        end
                        default: ;
                    endcase
                end
            end
            prev_acc  = bus_if.iocs;
            prev_addr = bus_if.ioaddr;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulus
        int snap;
        int tx_base;
        int n;
        bus_if.rda = 1'b0;
        bus_if.tbr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rst_iocs", 32'(bus_if.iocs), 32'd0);
        checkOutput("rst_iorw", 32'(bus_if.iorw), 32'd1);
        checkOutput("rst_ioaddr", 32'(bus_if.ioaddr), 32'd0);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        probe = 1'b1;
        #1 checkOutput("rst_bus_released", 32'(bus_if.databus), 32'h5A);
        probe = 1'b0;

        // Divisor programming after reset with 4800 baud
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        checkOutput("cfg_lo_access", 32'({bus_if.iocs, bus_if.iorw, bus_if.ioaddr}), 32'b1010);
        checkOutput("cfg_lo_data", 32'(bus_if.databus), 32'h45);
        tick();
        checkOutput("cfg_hi_access", 32'({bus_if.iocs, bus_if.iorw, bus_if.ioaddr}), 32'b1011);
        checkOutput("cfg_hi_data", 32'(bus_if.databus), 32'h01);
        tick();
        checkOutput("idle_iocs", 32'(bus_if.iocs), 32'd0);
        probe = 1'b1;
        #1 checkOutput("idle_bus_released", 32'(bus_if.databus), 32'h5A);
        probe = 1'b0;

        // Baud change 00 -> 11 while idle
        repeat (3) tick();
        br_cfg = 2'b11;
        tick();
        checkOutput("cfg38k_lo_access", 32'({bus_if.iocs, bus_if.iorw, bus_if.ioaddr}), 32'b1010);
        checkOutput("cfg38k_lo_data", 32'(bus_if.databus), 32'h28);
        tick();
        checkOutput("cfg38k_hi_data", 32'(bus_if.databus), 32'h00);
        snap = cfg_writes;
        repeat (10) tick();
        checkOutput("cfg_stable", cfg_writes, snap);

        // Single-byte echo latency
        bus_if.tbr = 1'b1;
        rx_byte = 8'h41;
        bus_if.rda = 1'b1;
        tick();
        checkOutput("lat_rd", 32'({bus_if.iocs, bus_if.iorw, bus_if.ioaddr}), 32'b1100);
        bus_if.rda = 1'b0;
        tick();
        checkOutput("lat_count1", 32'(fifo_count), 32'd1);
        checkOutput("lat_idle", 32'(bus_if.iocs), 32'd0);
        tick();
        checkOutput("lat_wr", 32'({bus_if.iocs, bus_if.iorw, bus_if.ioaddr}), 32'b1000);
        checkOutput("lat_wr_data", 32'(bus_if.databus), 32'h41);
        tick();
        checkOutput("lat_count0", 32'(fifo_count), 32'd0);

        // Three buffered bytes released in order once tbr rises
        repeat (4) tick();
        bus_if.tbr = 1'b0;
        applyStimulus(8'h31);
        applyStimulus(8'h32);
        applyStimulus(8'h33);
        checkOutput("burst_count", 32'(fifo_count), 32'd3);
        tx_base = tx_total;
        drain();
        checkOutput("burst_tx_total", tx_total - tx_base, 3);

        // Overflow: one byte more than the buffer holds
        bus_if.tbr = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(8'($urandom_range(0, 255)));
        end
        checkOutput("ovf_count", 32'(fifo_count), DEPTH);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        tx_base = tx_total;
        drain();
        checkOutput("ovf_tx_total", tx_total - tx_base, DEPTH);

        // Baud change and rda in the same idle cycle: configuration first
        bus_if.tbr = 1'b0;
        br_cfg = 2'b01;
        rx_byte = 8'h77;
        bus_if.rda = 1'b1;
        tick();
        checkOutput("prio_cfg_lo", 32'({bus_if.iocs, bus_if.ioaddr}), 32'b110);
        checkOutput("prio_cfg_lo_data", 32'(bus_if.databus), 32'hA2);
        tick();
        checkOutput("prio_cfg_hi", 32'({bus_if.iocs, bus_if.ioaddr}), 32'b111);
        tick();
        checkOutput("prio_idle", 32'(bus_if.iocs), 32'd0);
        tick();
        checkOutput("prio_rd", 32'({bus_if.iocs, bus_if.iorw, bus_if.ioaddr}), 32'b1100);
        bus_if.rda = 1'b0;
        tick();
        applyStimulus(8'h81);

        // Reset in the middle of a transmit write
        bus_if.tbr = 1'b1;
        n = 0;
        while (!(bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == ADDR_DATA) && n < 20) begin
            tick();
            n++;
        end
        checkOutput("wr_wait_timeout", 32'(n < 20), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_iocs", 32'(bus_if.iocs), 32'd0);
        checkOutput("midrst_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        probe = 1'b1;
        #1 checkOutput("midrst_bus_released", 32'(bus_if.databus), 32'h5A);
        probe = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        repeat (2) tick();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        checkOutput("post_rst_cfg_lo", 32'({bus_if.iocs, bus_if.ioaddr}), 32'b110);
        checkOutput("post_rst_cfg_data", 32'(bus_if.databus), 32'hA2);
        repeat (3) tick();

        // Randomized mix of receives, tbr toggles, baud changes and gaps
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                applyStimulus(8'($urandom_range(0, 255)));
            end else if (r < 7) begin
                bus_if.tbr = 1'($urandom_range(0, 1));
                tick();
            end else if (r == 7) begin
                if (!bus_if.iocs) br_cfg = 2'($urandom_range(0, 3));
                tick();
            end else begin
                repeat ($urandom_range(1, 4)) tick();
            end
        end
        drain();
        repeat (10) tick();
        checkOutput("final_divisor", 32'({last_hi, last_lo}), 32'(tbDiv(br_cfg)));
        checkOutput("final_empty", 32'(fifo_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
